// File: rtl/cpu_clock_pkg.sv
// Shared encodings for the processor clock sequencer and its button debouncer.
package cpu_clock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FREE  = 2'd1,
        ST_BURST = 2'd2,
        ST_TIMED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_FREE   = 2'd0,
        MODE_SINGLE = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_TIMED  = 2'd3
    } mode_t;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw board button, debounces it and emits a one-cycle pulse on
// each accepted press (0->1 of the debounced level).
module button_debouncer
    import cpu_clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int unsigned   CW   = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_clock_sequencer.sv
// Generates the processor clock-enable pulse at clock50/DIV, gated by the run
// mode (free, single-step, burst, timed) selected when the step button is pressed.
module cpu_clock_sequencer
    import cpu_clock_pkg::*;
#(
    parameter int unsigned DIV        = 50,
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned TIMEOUT    = 500000000,
    parameter int unsigned NW         = 16
) (
    input  logic          clock50,
    input  logic          rst,
    input  logic          step,
    input  logic [1:0]    mode,
    input  logic [NW-1:0] n_cycles,
    input  logic          halt,
    output logic          cpu_en,
    output logic          running,
    output logic [1:0]    state_o,
    output logic [31:0]   cycle_count
);

    localparam int unsigned PW = cnt_w(DIV - 1);
    localparam int unsigned TW = cnt_w(TIMEOUT);

    state_t        state;
    logic [PW-1:0] presc;
    logic [NW-1:0] remaining;
    logic [TW-1:0] timer;
    logic          tick;
    logic          press;

    button_debouncer #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_deb (
        .clk  (clock50),
        .rst  (rst),
        .raw  (step),
        .press(press)
    );

    // Enable is decoded from registered state so it can never last two cycles.
    assign tick    = (presc == PW'(DIV - 1));
    assign cpu_en  = tick & (state != ST_IDLE) & ~halt;
    assign running = (state != ST_IDLE);
    assign state_o = state;

    always_ff @(posedge clock50) begin
        if (rst) begin
            state       <= ST_IDLE;
            presc       <= '0;
            remaining   <= '0;
            timer       <= '0;
            cycle_count <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (cpu_en) begin
                cycle_count <= cycle_count + 32'd1;
            end

            if (halt) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (press) begin
                            case (mode_t'(mode))
                                MODE_FREE: state <= ST_FREE;
                                MODE_SINGLE: begin
                                    state     <= ST_BURST;
                                    remaining <= NW'(1);
                                end
                                MODE_BURST: begin
                                    if (n_cycles != '0) begin
                                        state     <= ST_BURST;
                                        remaining <= n_cycles;
                                    end
                                end
                                MODE_TIMED: begin
                                    state <= ST_TIMED;
                                    timer <= TW'(TIMEOUT);
                                end
                            endcase
                        end
                    end
                    ST_FREE: begin
                        if (press) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_BURST: begin
                        if (cpu_en) begin
                            if (remaining == NW'(1)) begin
                                state <= ST_IDLE;
                            end
                            remaining <= remaining - NW'(1);
                        end
                    end
                    ST_TIMED: begin
                        // Expiry wins over a simultaneous retrigger.
                        if (timer == TW'(1)) begin
                            state <= ST_IDLE;
                        end else if (press) begin
                            timer <= TW'(TIMEOUT);
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// Bench for cpu_clock_sequencer: directed run-mode scenarios plus random stimulus,
// all outputs compared every cycle against a behavioural model.
module tb_cpu_clock_sequencer;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int TMO = 20;
    localparam int NW  = 16;

    logic          clock50 = 1'b0;
    logic          rst = 1'b1;
    logic          step = 1'b0;
    logic          halt = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [NW-1:0] n_cycles = '0;
    logic          cpu_en;
    logic          running;
    logic [1:0]    state_o;
    logic [31:0]   cycle_count;

    int checks = 0;
    int errors = 0;

    cpu_clock_sequencer #(
        .DIV(DIV), .DEB_CYCLES(DEB), .TIMEOUT(TMO), .NW(NW)
    ) dut (
        .clock50(clock50),
        .rst(rst),
        .step(step),
        .mode(mode),
        .n_cycles(n_cycles),
        .halt(halt),
        .cpu_en(cpu_en),
        .running(running),
        .state_o(state_o),
        .cycle_count(cycle_count)
    );

    always #10 clock50 = ~clock50;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock50);
        #2;
    endtask

    // Behavioural model: cycle index, prescaler phase as a modulo count,
    // debounce as a window over synced samples, timed run as an absolute deadline.
    bit          armed = 1'b0;
    int          m_cyc = 0;
    int          m_ph = 0;
    int          m_st = 0;
    int          m_left = 0;
    int          m_deadline = 0;
    logic [31:0] m_cc = '0;
    bit          m_lvl = 1'b0;
    bit          m_press = 1'b0;
    bit          hist[$];
    bit          sq[$];

    always @(posedge clock50) begin
        bit s2;
        bit all_diff;
        bit en_m;
        if (rst) begin
            armed = 1'b1;
            hist.delete();
            sq.delete();
            m_lvl = 1'b0;
            m_press = 1'b0;
            m_ph = 0;
            m_st = 0;
            m_left = 0;
            m_cc = '0;
        end else begin
            en_m = (m_ph == DIV - 1) && (m_st != 0) && !halt;
            if (en_m) m_cc = m_cc + 32'd1;
            if (halt) begin
                m_st = 0;
            end else begin
                case (m_st)
                    0: if (m_press) begin
                        case (int'(mode))
                            0: m_st = 1;
                            1: begin m_st = 2; m_left = 1; end
                            2: if (n_cycles != 0) begin m_st = 2; m_left = int'(n_cycles); end
                            default: begin m_st = 3; m_deadline = m_cyc + 1 + TMO; end
                        endcase
                    end
                    1: if (m_press) m_st = 0;
                    2: if (en_m) begin
                        m_left--;
                        if (m_left == 0) m_st = 0;
                    end
                    default: begin
                        if (m_cyc == m_deadline - 1) m_st = 0;
                        else if (m_press) m_deadline = m_cyc + 1 + TMO;
                    end
                endcase
            end
            m_ph = (m_ph + 1) % DIV;

            s2 = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b0;
            hist.push_back(step);
            if (hist.size() > 4) void'(hist.pop_front());
            sq.push_back(s2);
            if (sq.size() > DEB) void'(sq.pop_front());
            all_diff = (sq.size() == DEB);
            foreach (sq[i]) if (sq[i] == m_lvl) all_diff = 1'b0;
            m_press = 1'b0;
            if (all_diff) begin
                m_lvl = !m_lvl;
                m_press = m_lvl;
                sq.delete();
            end
        end
        m_cyc++;
    end

    int npulse = 0;
    int n3 = 0;

    always @(negedge clock50) begin
        bit en_exp;
        if (armed) begin
            en_exp = (m_ph == DIV - 1) && (m_st != 0) && !halt;
            chk("state", state_o, m_st);
            chk("cpu_en", cpu_en, en_exp);
            chk("running", running, m_st != 0);
            chk("cycle_count", cycle_count, m_cc);
            if (cpu_en) npulse++;
            if (state_o == 2'd3) n3++;
        end
    end

    task automatic press_btn(input int hold, input int gap);
        step = 1'b1;
        wait_cyc(hold);
        step = 1'b0;
        wait_cyc(gap);
    endtask

    initial begin
        int b0;
        int b3;
        int t;

        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        chk("rst_state", state_o, 0);
        chk("rst_cc", cycle_count, 0);
        chk("rst_en", cpu_en, 0);

        for (int i = 0; i < 10; i++) begin
            step = ~step;
            wait_cyc(1);
        end
        step = 1'b0;
        wait_cyc(8);
        chk("bounce_state", state_o, 0);
        chk("bounce_cc", cycle_count, 0);

        mode = 2'b01;
        for (int i = 0; i < 3; i++) begin
            press_btn(10, 14);
            chk("single_idle", state_o, 0);
        end
        chk("single_cc", cycle_count, 3);

        mode = 2'b10;
        n_cycles = 16'd5;
        b0 = npulse;
        press_btn(10, 30);
        chk("burst_pulses", npulse - b0, 5);
        chk("burst_idle", state_o, 0);
        n_cycles = 16'd0;
        press_btn(10, 20);
        chk("burst_zero_state", state_o, 0);
        chk("burst_zero_cc", cycle_count, 8);

        mode = 2'b11;
        b0 = npulse;
        b3 = n3;
        press_btn(10, 30);
        chk("timed_pulses", npulse - b0, 5);
        chk("timed_len", n3 - b3, 20);
        // Second press is accepted 12 cycles into the run.
        b3 = n3;
        press_btn(5, 8);
        press_btn(5, 40);
        chk("retrig_len", n3 - b3, 33);

        mode = 2'b00;
        press_btn(10, 10);
        b0 = npulse;
        wait_cyc(20);
        chk("free_pulses", npulse - b0, 5);
        chk("free_running", running, 1);
        for (t = 0; t < 8 && m_ph != DIV - 1; t++) wait_cyc(1);
        halt = 1'b1;
        #5;
        chk("halt_en_gate", cpu_en, 0);
        wait_cyc(1);
        chk("halt_idle", state_o, 0);
        press_btn(10, 10);
        chk("halt_press_ignored", state_o, 0);
        halt = 1'b0;
        wait_cyc(5);
        chk("halt_release_idle", state_o, 0);

        mode = 2'b10;
        n_cycles = 16'd6;
        b0 = npulse;
        step = 1'b1;
        for (t = 0; t < 200; t++) begin
            wait_cyc(1);
            if (t == 10) step = 1'b0;
            if (npulse - b0 >= 3) break;
        end
        step = 1'b0;
        chk("rst_burst_reached", npulse - b0, 3);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("rst_burst_state", state_o, 0);
        chk("rst_burst_cc", cycle_count, 0);
        b0 = npulse;
        wait_cyc(20);
        chk("rst_burst_quiet", npulse - b0, 0);

        for (int i = 0; i < 250; i++) begin
            mode = 2'($urandom_range(3));
            n_cycles = NW'($urandom_range(7));
            step = 1'($urandom_range(1));
            halt = ($urandom_range(9) == 0);
            rst = ($urandom_range(39) == 0);
            wait_cyc(rst ? 1 : int'($urandom_range(12, 1)));
            rst = 1'b0;
        end
        halt = 1'b0;
        step = 1'b0;
        wait_cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
